prefetch_queue: RTL
===================

// Module: prefetch_queue
// PURPOSE
//  Parametrised 6502 instruction prefetch unit, successor to the per-byte fetcher.
//  Streams opcode/operand bytes from memory into a DEPTH-byte FIFO ahead of the decoder.
//  Decodes instruction length and presents whole instructions (1-3 bytes) in one valid/ready handshake.
//  Sits between the memory bus arbiter and the decoder/execute stage; flushed by taken branches, jumps and interrupts.
// PARAMETERS
//  REG_WIDTH   `REG_WIDTH (8)           data/byte width
//  ADDR_WIDTH  `ADDR_WIDTH (16)         address width
//  DEPTH       4                        FIFO bytes; power of 2, >= 4
//  RESET_PC    `INSTRUCTION_BASE        fetch address loaded at reset
// PORTS
//  phi1         in   1           clock; all state updates on posedge
//  reset_n      in   1           async active-low reset
//  redirect     in   1           load redirect_pc, flush queue
//  redirect_pc  in   ADDR_WIDTH  new fetch address
//  mem_req      out  1           byte read request
//  mem_addr     out  ADDR_WIDTH  read address; valid while mem_req=1
//  mem_gnt      in   1           request accepted this cycle
//  mem_data     in   REG_WIDTH   read data, valid exactly 1 cycle after an accepted req
//  instr_valid  out  1           full instruction at queue head
//  instr_ready  in   1           decoder consumes head instruction
//  instr_opcode out  REG_WIDTH   head byte
//  instr_op_lo  out  REG_WIDTH   head+1 (0 if len<2)
//  instr_op_hi  out  REG_WIDTH   head+2 (0 if len<3)
//  instr_len    out  2           1, 2 or 3
//  instr_pc     out  ADDR_WIDTH  address of opcode
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, head_pc=RESET_PC, count=0, inflight=0, state=S_FILL;
//   mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_op*/opcode=0, instr_len=1, instr_pc=RESET_PC.
//  FSM: S_FILL -> S_FULL when count+inflight==DEPTH; S_FULL -> S_FILL when pop frees space;
//   any state -> S_FLUSH on redirect; S_FLUSH -> S_FILL next cycle (1-cycle bubble, mem_req=0).
//  mem_req=1 in S_FILL when count+inflight<DEPTH; mem_addr=fetch_pc; on mem_gnt: fetch_pc+=1, inflight=1.
//  At most 1 outstanding read; returning byte written at tail next cycle, count+=1, inflight=0.
//  fetch_pc wraps 16'hFFFF -> 16'h0000; queue addresses are contiguous across the wrap.
//  Length decode (cc=op[1:0], bbb=op[4:2]): bbb=3 or 7 -> 3; bbb=6: cc=01 -> 3 else 1;
//   bbb=2: cc=01 -> 2 else 1; bbb=1,4,5 -> 2; bbb=0: op=20 -> 3, op=00/40/60 -> 1, else 2.
//  instr_valid = count>=1 && count>=len(head); combinational from registered queue state.
//  Pop on instr_valid&&instr_ready: count-=len, head_pc+=len (wraps), head ptr mod DEPTH.
//  Pop and same-cycle data return: count updates by (+1 - len) in one cycle.
//  redirect: count=0, head/tail ptr=0, fetch_pc=head_pc=redirect_pc; in-flight byte
//   returning next cycle is discarded; redirect beats a simultaneous pop (pop ignored).
//  redirect during S_FLUSH re-arms flush with the newest redirect_pc.
//  instr_valid never asserts with a partially fetched instruction; outputs held stable while valid&&!ready.
// CONFIGURATION
//  FETCH_STALL_CNT_EN defined: extra port stall_cnt out 16: counts cycles with
//   instr_ready=1 && instr_valid=0; saturates at 16'hFFFF; reset to 0; not cleared by redirect.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  Reset, RESET_PC=16'h8000, mem_gnt=1, mem holds A9 05 -> mem_addr 8000,8001..; instr_valid with opcode=A9,
//   op_lo=05, len=2, pc=8000.
//  Queue 4C 34 12 (JMP abs), instr_ready=0 -> holds at count=DEPTH, mem_req=0; ready=1 -> len=3, op_hi=12.
//  Pop 4C then redirect to 1234 with byte in flight -> stale byte dropped, next mem_addr=1234, 1-cycle bubble.
//  redirect_pc=FFFE, mem EA @FFFE, 20 @FFFF, 00 10 @0000 -> EA len=1 pc=FFFE, then 20 len=3 pc=FFFF op_lo=00 op_hi=10.
//  mem_gnt low 3 cycles -> mem_req held, mem_addr stable, fetch_pc unchanged; redirect+pop same cycle -> redirect wins.
//  FETCH_STALL_CNT_EN: ready=1 through 5 empty cycles after reset -> stall_cnt=5; force 70000 -> FFFF.

Source files
------------

// File: rtl/prefetch_queue.sv
// 6502 instruction prefetch queue: streams bytes into a DEPTH-byte FIFO and presents whole 1-3 byte instructions.
// Define FETCH_STALL_CNT_EN to add the stall_cnt port (decoder-starved cycle counter).
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef INSTRUCTION_BASE
`define INSTRUCTION_BASE 16'h8000
`endif

module prefetch_queue #(
  parameter int unsigned REG_WIDTH = `REG_WIDTH,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(`INSTRUCTION_BASE)
) (
  input  logic                  phi1,
  input  logic                  reset_n,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [REG_WIDTH-1:0]  mem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [REG_WIDTH-1:0]  instr_opcode,
  output logic [REG_WIDTH-1:0]  instr_op_lo,
  output logic [REG_WIDTH-1:0]  instr_op_hi,
  output logic [1:0]            instr_len,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {S_FILL, S_FULL, S_FLUSH} state_t;

  state_t                  state, n_state;
  logic [ADDR_WIDTH-1:0]   fetch_pc, n_fetch_pc;
  logic [ADDR_WIDTH-1:0]   head_pc, n_head_pc;
  logic [PW-1:0]           head_ptr, n_head_ptr;
  logic [PW-1:0]           tail_ptr, n_tail_ptr;
  logic [CW-1:0]           count, n_count;
  logic                    inflight, n_inflight;
  logic                    n_mem_req;
  logic                    wr_en;
  logic [SW-1:0]           n_fill;
  logic [REG_WIDTH-1:0]    fifo [DEPTH];
  logic [PW-1:0]           idx1, idx2;
  logic [REG_WIDTH-1:0]    head_op;
  logic [1:0]              head_len;
  logic                    pop, gnt;

  // Instruction length from the 6502 opcode map (cc = op[1:0], bbb = op[4:2]).
  function automatic logic [1:0] decode_len(input logic [REG_WIDTH-1:0] op);
    logic [1:0] cc;
    logic [2:0] bbb;
    cc  = op[1:0];
    bbb = op[4:2];
    case (bbb)
      3'd3, 3'd7:       decode_len = 2'd3;
      3'd6:             decode_len = (cc == 2'b01) ? 2'd3 : 2'd1;
      3'd2:             decode_len = (cc == 2'b01) ? 2'd2 : 2'd1;
      3'd1, 3'd4, 3'd5: decode_len = 2'd2;
      default: begin
        if (op == REG_WIDTH'(8'h20))
          decode_len = 2'd3;
        else if (op == REG_WIDTH'(8'h00) || op == REG_WIDTH'(8'h40) || op == REG_WIDTH'(8'h60))
          decode_len = 2'd1;
        else
          decode_len = 2'd2;
      end
    endcase
  endfunction

  assign idx1     = head_ptr + PW'(1);
  assign idx2     = head_ptr + PW'(2);
  assign head_op  = fifo[head_ptr];
  assign head_len = decode_len(head_op);

  assign instr_valid  = (count != '0) && (count >= CW'(head_len));
  assign instr_opcode = head_op;
  assign instr_op_lo  = (head_len >= 2'd2) ? fifo[idx1] : '0;
  assign instr_op_hi  = (head_len == 2'd3) ? fifo[idx2] : '0;
  assign instr_len    = head_len;
  assign instr_pc     = head_pc;

  assign pop   = instr_valid && instr_ready;
  assign gnt   = mem_req && mem_gnt;
  assign wr_en = inflight && !redirect;

  // Next-state: redirect overrides everything, including a same-cycle pop and a returning byte.
  always_comb begin
    n_state    = state;
    n_fetch_pc = fetch_pc;
    n_head_pc  = head_pc;
    n_head_ptr = head_ptr;
    n_tail_ptr = tail_ptr;
    n_count    = count;
    n_inflight = inflight;
    if (redirect) begin
      n_state    = S_FLUSH;
      n_fetch_pc = redirect_pc;
      n_head_pc  = redirect_pc;
      n_head_ptr = '0;
      n_tail_ptr = '0;
      n_count    = '0;
      n_inflight = 1'b0;
    end else begin
      n_inflight = gnt;
      if (gnt) n_fetch_pc = fetch_pc + ADDR_WIDTH'(1);
      if (wr_en) n_tail_ptr = tail_ptr + PW'(1);
      if (pop) begin
        n_head_ptr = head_ptr + PW'(head_len);
        n_head_pc  = head_pc + ADDR_WIDTH'(head_len);
      end
      n_count = count + CW'(inflight) - (pop ? CW'(head_len) : CW'(0));
    end
    n_fill = SW'(n_count) + SW'(n_inflight);
    if (!redirect) begin
      if (state == S_FLUSH)
        n_state = S_FILL;
      else
        n_state = (n_fill == SW'(DEPTH)) ? S_FULL : S_FILL;
    end
    n_mem_req = (n_state == S_FILL) && (n_fill < SW'(DEPTH));
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FILL;
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      inflight <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      for (int i = 0; i < int'(DEPTH); i++) fifo[i] <= '0;
    end else begin
      state    <= n_state;
      fetch_pc <= n_fetch_pc;
      head_pc  <= n_head_pc;
      head_ptr <= n_head_ptr;
      tail_ptr <= n_tail_ptr;
      count    <= n_count;
      inflight <= n_inflight;
      mem_req  <= n_mem_req;
      mem_addr <= n_fetch_pc;
      if (wr_en) fifo[tail_ptr] <= mem_data;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Cycles the decoder wanted an instruction but none was ready; saturating, survives redirects.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (instr_ready && !instr_valid && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
